sim_ctrl_responder: RTL and testbench
=====================================

SIM_CTRL_RESPONDER -- requirements
Module: sim_ctrl_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1000_0000, giving the base of the 32-byte register window.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the stdout FIFO depth; it SHALL be a power of two, >= 2.
REQ-003 Port clk_i, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_i, input, 1: synchronous, active-high reset.
REQ-005 Port data_req_i, input, 1: OBI request from the core data port.
REQ-006 Port data_gnt_o, output, 1: OBI grant.
REQ-007 Port data_addr_i, input, 32: byte address.
REQ-008 Port data_we_i, input, 1: 1 = write, 0 = read.
REQ-009 Port data_be_i, input, 4: byte enables.
REQ-010 Port data_wdata_i, input, 32: write data.
REQ-011 Port data_rvalid_o, output, 1: response valid.
REQ-012 Port data_rdata_o, output, 32: read data, qualified by data_rvalid_o.
REQ-013 Port data_err_o, output, 1: error response, qualified by data_rvalid_o.
REQ-014 Port char_valid_o, output, 1: a stdout character is available.
REQ-015 Port char_data_o, output, 8: stdout character.
REQ-016 Port char_ready_i, input, 1: the consumer accepts the character.
REQ-017 Ports tests_passed_o, tests_failed_o and exit_valid_o, outputs, 1 each: sticky terminal flags.
REQ-018 Port exit_value_o, output, 32: exit code, valid while exit_valid_o is high.

Function
REQ-019 Register offsets from BASE_ADDR SHALL be: 0x00 PRINT (W), 0x04 PASS (W), 0x08 FAIL (W), 0x0C EXIT (W), 0x10 STATUS (R); every other offset in the window is unmapped.
REQ-020 Requests with the address outside [BASE_ADDR, BASE_ADDR+0x1F] SHALL NOT be granted and SHALL have no effect.
REQ-021 data_gnt_o SHALL be combinational: req in window AND NOT (write to PRINT while FIFO full AND state RUN).
REQ-022 Exactly one response SHALL be produced per grant: data_rvalid_o is high in the cycle after the grant, for one cycle; back-to-back grants SHALL produce back-to-back responses.
REQ-023 A granted PRINT write in state RUN with data_be_i[0]=1 SHALL push data_wdata_i[7:0] into the FIFO; if be[0]=0, nothing is pushed and the response is OKAY.
REQ-024 The FIFO SHALL present its head on char_data_o with char_valid_o = not empty; a pop SHALL occur when char_valid_o and char_ready_i are both high.
REQ-025 A pushed character SHALL first be visible on char_valid_o the cycle after the push; there is no bypass path.
REQ-026 A pop SHALL NOT free space for a grant in the same cycle; there SHALL be no combinational path from char_ready_i to data_gnt_o.
REQ-027 Simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 The state machine SHALL have states RUN, DRAIN and DONE.
REQ-029 In state RUN, a granted write to PASS, FAIL or EXIT SHALL latch the event kind (and data_wdata_i for EXIT, regardless of data_be_i) and move to DRAIN.
REQ-030 DRAIN SHALL move to DONE on the first cycle in which the FIFO is empty.
REQ-031 On entering DONE, the matching flag (with exit_value_o for EXIT) SHALL assert and hold until reset.
REQ-032 Only the first terminal event SHALL count; in DRAIN and DONE, writes to PRINT, PASS, FAIL and EXIT SHALL be granted, answered OKAY and discarded.
REQ-033 A STATUS read SHALL return rdata = {14'b0, state[1:0] (RUN=0, DRAIN=1, DONE=2), 6'b0, empty, full, count[7:0]}, with count zero-extended.
REQ-034 A read of a write-only or unmapped offset, or a write to STATUS or an unmapped offset, SHALL respond with data_err_o=1, rdata=0 and no side effect.
REQ-035 data_rdata_o SHALL be 0 and data_err_o SHALL be 0 whenever data_rvalid_o is 0.

Reset
REQ-036 While rst_i is sampled high: the FIFO SHALL empty and the state SHALL become RUN.
REQ-037 On the cycle after rst_i is sampled high, data_rvalid_o, data_err_o, char_valid_o, all three flags, exit_value_o and data_rdata_o SHALL be 0.
REQ-038 A request outstanding at reset SHALL receive no response; data_gnt_o SHALL be 0 while rst_i is high.

Verification
REQ-039 Write PRINT 0x48, 0x69 with char_ready_i=1 -> char_data_o shows 0x48 then 0x69, each appearing the cycle after its push; rvalid is seen 1 cycle after each gnt.
REQ-040 With char_ready_i=0, do 9 PRINT writes -> 8 granted, 9th held with gnt=0; STATUS blocked; raise ready -> 9th granted the cycle after the first pop; chars in order.
REQ-041 Fill 3 chars with ready=0, write EXIT 0x5, then raise ready -> exit_valid_o=0 until the FIFO is empty; DONE the next cycle with exit_value_o=5; a later FAIL write leaves tests_failed_o=0.
REQ-042 Read offset 0x04 and write offset 0x14 -> rvalid with err=1, rdata=0, no state change; a read at BASE_ADDR+0x20 gets no gnt.
REQ-043 Assert rst_i for one cycle mid-DRAIN with 2 chars queued -> next cycle char_valid_o=0, all flags 0, STATUS reads 0x0000_0200.

Source files
------------

// File: rtl/sim_ctrl_responder.sv
// Simulation control responder: memory-mapped stdout FIFO plus PASS/FAIL/EXIT
// terminal flags, attached to an OBI data port with single-cycle responses.
module sim_ctrl_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [4:0] OFF_PRINT  = 5'h00;
  localparam logic [4:0] OFF_PASS   = 5'h04;
  localparam logic [4:0] OFF_FAIL   = 5'h08;
  localparam logic [4:0] OFF_EXIT   = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EV_PASS = 2'd0,
    EV_FAIL = 2'd1,
    EV_EXIT = 2'd2
  } event_e;

  state_e            state_q;
  event_e            event_q;
  logic [31:0]       exit_data_q;
  logic              passed_q, failed_q, exit_valid_q;
  logic [31:0]       exit_value_q;

  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              rvalid_q, err_q;
  logic [31:0]       rdata_q;
  logic              err_d;
  logic [31:0]       rdata_d;

  logic [31:0]       offset;
  logic [4:0]        reg_off;
  logic              in_window, fifo_empty, fifo_full;
  logic              is_print_wr, is_term_wr, push, pop;
  logic [31:0]       status_word;
  logic              unused_be;

  assign unused_be = ^data_be_i[3:1];

  // Unsigned subtraction wraps addresses below the base to large values.
  assign offset    = data_addr_i - BASE_ADDR;
  assign in_window = offset < 32'd32;
  assign reg_off   = offset[4:0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  assign is_print_wr = data_we_i && (reg_off == OFF_PRINT);
  assign is_term_wr  = data_we_i &&
                       (reg_off == OFF_PASS || reg_off == OFF_FAIL || reg_off == OFF_EXIT);

  // Backpressure uses the registered full flag only, so a pop never frees a slot same-cycle.
  assign data_gnt_o = data_req_i && in_window && !rst_i &&
                      !(is_print_wr && fifo_full && (state_q == ST_RUN));

  assign push = data_gnt_o && is_print_wr && (state_q == ST_RUN) && data_be_i[0];
  assign pop  = !fifo_empty && char_ready_i;

  assign status_word = {14'b0, state_q, 6'b0, fifo_empty, fifo_full, 8'(count_q)};

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    err_d   = 1'b0;
    rdata_d = '0;
    if (data_we_i) begin
      err_d = !(reg_off == OFF_PRINT || is_term_wr);
    end else if (reg_off == OFF_STATUS) begin
      rdata_d = status_word;
    end else begin
      err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= data_gnt_o;
      err_q    <= data_gnt_o && err_d;
      rdata_q  <= data_gnt_o ? rdata_d : '0;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;

  // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= data_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign char_valid_o = !fifo_empty;
  assign char_data_o  = fifo_mem_q[rd_ptr_q];

  // Only the first terminal event is latched; the flags follow once stdout has drained.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      event_q      <= EV_PASS;
      exit_data_q  <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (data_gnt_o && is_term_wr) begin
            state_q     <= ST_DRAIN;
            exit_data_q <= data_wdata_i;
            if (reg_off == OFF_PASS)      event_q <= EV_PASS;
            else if (reg_off == OFF_FAIL) event_q <= EV_FAIL;
            else                          event_q <= EV_EXIT;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_q <= ST_DONE;
            case (event_q)
              EV_PASS: passed_q <= 1'b1;
              EV_FAIL: failed_q <= 1'b1;
              default: begin
                exit_valid_q <= 1'b1;
                exit_value_q <= exit_data_q;
              end
            endcase
          end
        end
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_sim_ctrl_responder.sv
// Directed and random checks of sim_ctrl_responder against a queue-based
// behavioural model of the register window, stdout FIFO and terminal flags.
module tb_sim_ctrl_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i, data_req_i, data_we_i, char_ready_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o, char_valid_o;
  logic [31:0] data_rdata_o, exit_value_o;
  logic [7:0]  char_data_o;
  logic        tests_passed_o, tests_failed_o, exit_valid_o;

  sim_ctrl_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .char_valid_o   (char_valid_o),
    .char_data_o    (char_data_o),
    .char_ready_i   (char_ready_i),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: stdout contents as a byte queue, state as 0=RUN 1=DRAIN 2=DONE.
  byte unsigned m_q[$];
  int           m_state = 0;
  int           m_kind  = 0;
  logic [31:0]  m_pend_val = '0;
  logic         m_pass = 1'b0, m_fail = 1'b0, m_exit = 1'b0;
  logic [31:0]  m_exit_val = '0;
  logic         m_rvalid = 1'b0, m_err = 1'b0;
  logic [31:0]  m_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_gnt();
    logic [31:0] off;
    off = data_addr_i - BASE;
    if (rst_i || !data_req_i || off > 32'd31) return 1'b0;
    if (data_we_i && off == 32'd0 && m_state == 0 && m_q.size() == DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_edge(input logic g);
    logic [31:0] off;
    int          st0;
    bit          was_empty, pop;
    off = data_addr_i - BASE;
    if (rst_i) begin
      m_q.delete();
      m_state = 0;
      m_pass = 1'b0; m_fail = 1'b0; m_exit = 1'b0; m_exit_val = '0;
      m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
      return;
    end
    st0       = m_state;
    was_empty = (m_q.size() == 0);
    pop       = !was_empty && char_ready_i;
    m_rvalid  = g;
    m_err     = 1'b0;
    m_rdata   = '0;
    if (g && !data_we_i) begin
      if (off == 32'h10)
        m_rdata = {14'b0, 2'(st0), 6'b0, was_empty, m_q.size() == DEPTH, 8'(m_q.size())};
      else
        m_err = 1'b1;
    end else if (g && !(off inside {32'h0, 32'h4, 32'h8, 32'hC})) begin
      m_err = 1'b1;
    end
    if (st0 == 1 && was_empty) begin
      m_state = 2;
      case (m_kind)
        0:       m_pass = 1'b1;
        1:       m_fail = 1'b1;
        default: begin m_exit = 1'b1; m_exit_val = m_pend_val; end
      endcase
    end else if (st0 == 0 && g && data_we_i && (off inside {32'h4, 32'h8, 32'hC})) begin
      m_state    = 1;
      m_kind     = (off == 32'h4) ? 0 : (off == 32'h8) ? 1 : 2;
      m_pend_val = data_wdata_i;
    end
    if (pop) void'(m_q.pop_front());
    if (g && data_we_i && off == 32'h0 && st0 == 0 && data_be_i[0])
      m_q.push_back(data_wdata_i[7:0]);
  endfunction

  task automatic drive(input logic req, input logic we, input logic [31:0] off,
                       input logic [31:0] wdata, input logic [3:0] be);
    data_req_i   = req;
    data_we_i    = we;
    data_addr_i  = BASE + off;
    data_wdata_i = wdata;
    data_be_i    = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic post_check(input string tag);
    check({tag, ".rvalid"}, data_rvalid_o, m_rvalid);
    check({tag, ".err"}, data_err_o, m_err);
    check({tag, ".rdata"}, data_rdata_o, m_rdata);
    check({tag, ".cvalid"}, char_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) check({tag, ".cdata"}, char_data_o, m_q[0]);
    check({tag, ".pass"}, tests_passed_o, m_pass);
    check({tag, ".fail"}, tests_failed_o, m_fail);
    check({tag, ".xvalid"}, exit_valid_o, m_exit);
    check({tag, ".xvalue"}, exit_value_o, m_exit_val);
  endtask

  // Inputs are already driven; compare grant mid-cycle, then outputs 1 time unit after the edge.
  task automatic tick(input string tag);
    logic g;
    #1;
    g = model_gnt();
    check({tag, ".gnt"}, data_gnt_o, g);
    model_edge(g);
    @(posedge clk_i);
    #1;
    post_check(tag);
  endtask

  initial begin
    rst_i = 1'b1;
    char_ready_i = 1'b0;
    idle();
    tick("rst0");
    tick("rst1");
    check("rst.rvalid", data_rvalid_o, 1'b0);
    check("rst.cvalid", char_valid_o, 1'b0);
    rst_i = 1'b0;

    // Two characters with the consumer always ready.
    char_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'h0, 32'h48, 4'h1);
    tick("hi.w0");
    check("hi.rv0", data_rvalid_o, 1'b1);
    check("hi.c0", {char_valid_o, char_data_o}, 9'h148);
    drive(1'b1, 1'b1, 32'h0, 32'h69, 4'h1);
    tick("hi.w1");
    check("hi.c1", {char_valid_o, char_data_o}, 9'h169);
    idle();
    tick("hi.idle");
    check("hi.c2", char_valid_o, 1'b0);
    check("hi.rv2", data_rvalid_o, 1'b0);

    // Byte enable 0 on PRINT: OKAY response, nothing queued.
    drive(1'b1, 1'b1, 32'h0, 32'h77, 4'hE);
    tick("be0");
    check("be0.cvalid", char_valid_o, 1'b0);

    // Fill the FIFO, hold the ninth write, then release the consumer.
    char_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 32'h0, 32'h30 + i, 4'hF);
      tick("fill");
    end
    drive(1'b1, 1'b1, 32'h0, 32'h38, 4'hF);
    tick("held0");
    tick("held1");
    #1 check("held.gnt", data_gnt_o, 1'b0);
    char_ready_i = 1'b1;
    tick("pop0");
    tick("late");
    check("late.rvalid", data_rvalid_o, 1'b1);
    check("late.head", char_data_o, 8'h32);
    idle();
    for (int i = 0; i < 8; i++) tick("drain");
    check("drain.empty", char_valid_o, 1'b0);

    // EXIT with three characters still queued; flag waits for the drain.
    char_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h0, 32'h41 + i, 4'h1);
      tick("ex.fill");
    end
    drive(1'b1, 1'b1, 32'hC, 32'h5, 4'h0);
    tick("ex.exit");
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick("ex.stat");
    check("ex.status", data_rdata_o, 32'h0001_0003);
    idle();
    char_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("ex.pop");
      check("ex.xv_low", exit_valid_o, 1'b0);
    end
    tick("ex.done");
    check("ex.xvalid", exit_valid_o, 1'b1);
    check("ex.xvalue", exit_value_o, 32'h5);
    drive(1'b1, 1'b1, 32'h8, 32'h1, 4'hF);
    tick("ex.late_fail");
    check("ex.late_err", data_err_o, 1'b0);
    check("ex.no_fail", tests_failed_o, 1'b0);
    drive(1'b1, 1'b1, 32'h0, 32'h5A, 4'hF);
    tick("ex.late_print");
    check("ex.no_char", char_valid_o, 1'b0);

    // Error responses and out-of-window requests.
    drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    tick("err.rd4");
    check("err.rd4_err", data_err_o, 1'b1);
    check("err.rd4_data", data_rdata_o, 32'h0);
    drive(1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF);
    tick("err.wr14");
    check("err.wr14_err", data_err_o, 1'b1);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1 check("oob.gnt", data_gnt_o, 1'b0);
    tick("oob.hi");
    check("oob.rvalid", data_rvalid_o, 1'b0);
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 4'hF);
    tick("oob.lo");
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick("done.stat");
    check("done.status", data_rdata_o, 32'h0002_0200);

    // Reset in the middle of DRAIN with two characters queued.
    rst_i = 1'b1;
    idle();
    tick("rst2");
    rst_i = 1'b0;
    char_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h0, 32'h61 + i, 4'h1);
      tick("mid.fill");
    end
    drive(1'b1, 1'b1, 32'h4, 32'h0, 4'hF);
    tick("mid.pass");
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    rst_i = 1'b1;
    #1 check("mid.rst_gnt", data_gnt_o, 1'b0);
    tick("mid.rst");
    check("mid.cvalid", char_valid_o, 1'b0);
    check("mid.flags", {tests_passed_o, tests_failed_o, exit_valid_o}, 3'b000);
    check("mid.rvalid", data_rvalid_o, 1'b0);
    rst_i = 1'b0;
    tick("mid.stat");
    check("mid.status", data_rdata_o, 32'h0000_0200);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      int          sel;
      logic [31:0] off;
      sel = $urandom_range(0, 31);
      if (sel < 20)      off = 32'h0;
      else if (sel == 20) off = 32'h4;
      else if (sel == 21) off = 32'h8;
      else if (sel == 22) off = 32'hC;
      else if (sel < 27) off = 32'h10;
      else if (sel < 30) off = 32'($urandom_range(0, 31));
      else               off = 32'($urandom_range(32, 64));
      rst_i        = ($urandom_range(0, 29) == 0);
      char_ready_i = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), off,
            $urandom, 4'($urandom));
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
